// File: rtl/of_alu_pipe_reg.sv
// Elastic OF->ALU pipeline register: two-entry skid buffer with a registered ready_OF and a synchronous flush.
// Defining OFALU_PIPE_FWD_EN adds the rs*_OF inputs and the combinational fwd*_hit outputs.
module of_alu_pipe_reg #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ALU_SIG_W = 13,
   parameter int unsigned REG_AW    = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 valid_OF,
   output logic                 ready_OF,
   input  logic [DATA_W-1:0]    op1_OF,
   input  logic [DATA_W-1:0]    op2_OF,
   input  logic [ALU_SIG_W-1:0] aluSignals_OF,
   input  logic [REG_AW-1:0]    rd_OF,
   input  logic                 isWb_OF,
   input  logic                 flush,
`ifdef OFALU_PIPE_FWD_EN
   input  logic [REG_AW-1:0]    rs1_OF,
   input  logic [REG_AW-1:0]    rs2_OF,
   output logic                 fwd1_hit,
   output logic                 fwd2_hit,
`endif
   output logic                 valid_ALU,
   input  logic                 ready_ALU,
   output logic [DATA_W-1:0]    op1_ALU,
   output logic [DATA_W-1:0]    op2_ALU,
   output logic [ALU_SIG_W-1:0] aluSignals_ALU,
   output logic [REG_AW-1:0]    rd_ALU,
   output logic                 isWb_ALU
);

   typedef struct packed {
      logic [DATA_W-1:0]    op1;
      logic [DATA_W-1:0]    op2;
      logic [ALU_SIG_W-1:0] alu;
      logic [REG_AW-1:0]    rd;
      logic                 wb;
   } payload_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } occ_e;

   occ_e     state_q, state_d;
   payload_t out_q, out_d;
   payload_t skid_q, skid_d;
   payload_t in_pl;
   logic     ready_q, ready_d;
   logic     valid_q, valid_d;
   logic     acc, con;
   logic     ld_out_in, ld_out_skid, ld_skid;

   assign in_pl = '{op1: op1_OF, op2: op2_OF, alu: aluSignals_OF, rd: rd_OF, wb: isWb_OF};

   always_comb begin
      acc         = valid_OF & ready_q;
      con         = valid_q & ready_ALU;
      state_d     = state_q;
      ld_out_in   = 1'b0;
      ld_out_skid = 1'b0;
      ld_skid     = 1'b0;
      case (state_q)
         EMPTY: if (acc) begin
            state_d   = ONE;
            ld_out_in = 1'b1;
         end
         ONE: begin
            if (acc && con) begin
               ld_out_in = 1'b1;
            end else if (acc) begin
               state_d = FULL;
               ld_skid = 1'b1;
            end else if (con) begin
               state_d = EMPTY;
            end
         end
         FULL: if (con) begin
            state_d     = ONE;
            ld_out_skid = 1'b1;
         end
         default: state_d = EMPTY;
      endcase
      // Flush wins over everything, including an entry accepted this cycle.
      if (flush) begin
         state_d     = EMPTY;
         ld_out_in   = 1'b0;
         ld_out_skid = 1'b0;
         ld_skid     = 1'b0;
      end
      out_d = out_q;
      if (ld_out_in)
         out_d = in_pl;
      else if (ld_out_skid)
         out_d = skid_q;
      skid_d  = ld_skid ? in_pl : skid_q;
      ready_d = (state_d != FULL);
      valid_d = (state_d != EMPTY);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         out_q   <= '0;
         skid_q  <= '0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         skid_q  <= skid_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
      end
   end

   assign ready_OF       = ready_q;
   assign valid_ALU      = valid_q;
   assign op1_ALU        = out_q.op1;
   assign op2_ALU        = out_q.op2;
   assign aluSignals_ALU = out_q.alu;
   assign rd_ALU         = out_q.rd;
   assign isWb_ALU       = out_q.wb & valid_q;

`ifdef OFALU_PIPE_FWD_EN
   assign fwd1_hit = valid_q & out_q.wb & (out_q.rd == rs1_OF) & (rs1_OF != '0);
   assign fwd2_hit = valid_q & out_q.wb & (out_q.rd == rs2_OF) & (rs2_OF != '0);
`endif

endmodule

// File: tb/tb_of_alu_pipe_reg.sv
// Randomized and directed bench for of_alu_pipe_reg against a two-deep FIFO reference model.
module tb_of_alu_pipe_reg;

   typedef struct packed {
      logic [31:0] op1;
      logic [31:0] op2;
      logic [12:0] alu;
      logic [4:0]  rd;
      logic        wb;
   } pl_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid_OF, ready_OF, flush, valid_ALU, ready_ALU;
   logic [31:0] op1_OF, op2_OF, op1_ALU, op2_ALU;
   logic [12:0] aluSignals_OF, aluSignals_ALU;
   logic [4:0]  rd_OF, rd_ALU;
   logic        isWb_OF, isWb_ALU;
`ifdef OFALU_PIPE_FWD_EN
   logic [4:0]  rs1_OF, rs2_OF;
   logic        fwd1_hit, fwd2_hit;
`endif

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   pl_t         exp_q[$];

   of_alu_pipe_reg #(.DATA_W(32), .ALU_SIG_W(13), .REG_AW(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .valid_OF(valid_OF), .ready_OF(ready_OF),
      .op1_OF(op1_OF), .op2_OF(op2_OF), .aluSignals_OF(aluSignals_OF),
      .rd_OF(rd_OF), .isWb_OF(isWb_OF), .flush(flush),
`ifdef OFALU_PIPE_FWD_EN
      .rs1_OF(rs1_OF), .rs2_OF(rs2_OF), .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
`endif
      .valid_ALU(valid_ALU), .ready_ALU(ready_ALU),
      .op1_ALU(op1_ALU), .op2_ALU(op2_ALU), .aluSignals_ALU(aluSignals_ALU),
      .rd_ALU(rd_ALU), .isWb_ALU(isWb_ALU)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic pl_t rand_pl();
      pl_t p;
      p.op1 = $urandom;
      p.op2 = $urandom;
      p.alu = 13'($urandom);
      p.rd  = 5'($urandom);
      p.wb  = 1'($urandom);
      return p;
   endfunction

   task automatic check_outputs();
      pl_t got;
      got = '{op1: op1_ALU, op2: op2_ALU, alu: aluSignals_ALU, rd: rd_ALU, wb: 1'b0};
      chk("valid_ALU", 128'(valid_ALU), 128'(exp_q.size() > 0));
      chk("ready_OF", 128'(ready_OF), 128'(exp_q.size() < 2));
      if (exp_q.size() > 0) begin
         chk("isWb_ALU", 128'(isWb_ALU), 128'(exp_q[0].wb));
         chk("payload", 128'(got), 128'({exp_q[0].op1, exp_q[0].op2, exp_q[0].alu, exp_q[0].rd, 1'b0}));
      end else begin
         chk("isWb_ALU_bubble", 128'(isWb_ALU), 128'(0));
      end
   endtask

   // One clock: drive inputs, advance the FIFO model across the edge, check 1 time unit later.
   task automatic step(input logic v, input logic r, input logic f, input pl_t p, output bit accepted);
      bit acc, con;
      valid_OF = v; ready_ALU = r; flush = f;
      op1_OF = p.op1; op2_OF = p.op2; aluSignals_OF = p.alu; rd_OF = p.rd; isWb_OF = p.wb;
      acc = v && (exp_q.size() < 2);
      con = r && (exp_q.size() > 0);
      @(posedge clk);
      if (f) begin
         exp_q.delete();
      end else begin
         if (con) void'(exp_q.pop_front());
         if (acc) exp_q.push_back(p);
      end
      accepted = acc && !f;
      #1;
      check_outputs();
   endtask

   initial begin
      pl_t p;
      bit  a;
      rst_n = 1'b0; valid_OF = 1'b0; ready_ALU = 1'b0; flush = 1'b0;
      op1_OF = '0; op2_OF = '0; aluSignals_OF = '0; rd_OF = '0; isWb_OF = 1'b0;
`ifdef OFALU_PIPE_FWD_EN
      rs1_OF = '0; rs2_OF = '0;
`endif
      #12 rst_n = 1'b1;
      #1;
      chk("rst_ready", 128'(ready_OF), 128'(1));
      chk("rst_valid", 128'(valid_ALU), 128'(0));
      chk("rst_payload", 128'({op1_ALU, op2_ALU, aluSignals_ALU, rd_ALU, isWb_ALU}), 128'(0));

      // Streaming: 8 back-to-back entries.
      for (int i = 0; i < 8; i++) begin
         p = rand_pl(); p.op1 = 32'h10 + 32'(i);
         step(1'b1, 1'b1, 1'b0, p, a);
         chk("stream_acc", 128'(a), 128'(1));
      end
      p = rand_pl();
      step(1'b0, 1'b1, 1'b0, p, a);

      // Backpressure: A, B, C offered while stalled; C must wait.
      for (int i = 0; i < 3; i++) begin
         p = rand_pl(); p.op1 = 32'hA0 + 32'(i);
         step(1'b1, 1'b0, 1'b0, p, a);
      end
      chk("bp_skid_full", 128'(exp_q.size()), 128'(2));
      for (int i = 0; i < 4 && !a; i++)
         step(1'b1, 1'b1, 1'b0, p, a);
      chk("bp_c_accepted", 128'(a), 128'(1));
      p = rand_pl();
      step(1'b0, 1'b1, 1'b0, p, a);

      // Flush while FULL with a simultaneous offer D.
      p = rand_pl(); p.wb = 1'b1; step(1'b1, 1'b0, 1'b0, p, a);
      p = rand_pl(); p.wb = 1'b1; step(1'b1, 1'b0, 1'b0, p, a);
      p = rand_pl(); p.op1 = 32'hDDDD; step(1'b1, 1'b0, 1'b1, p, a);
      chk("flush_d_dropped", 128'(a), 128'(0));
      step(1'b0, 1'b1, 1'b0, p, a);

      // Flush in EMPTY, then one entry with single-cycle latency.
      step(1'b0, 1'b1, 1'b1, p, a);
      p = rand_pl(); step(1'b1, 1'b0, 1'b0, p, a);
      chk("post_flush_lat", 128'(op1_ALU), 128'(p.op1));

`ifdef OFALU_PIPE_FWD_EN
      step(1'b0, 1'b1, 1'b0, p, a);
      p = rand_pl(); p.rd = 5'd5; p.wb = 1'b1; step(1'b1, 1'b0, 1'b0, p, a);
      rs1_OF = 5'd5; rs2_OF = 5'd0; valid_OF = 1'b0; #1;
      chk("fwd1_hit", 128'(fwd1_hit), 128'(1));
      chk("fwd2_hit", 128'(fwd2_hit), 128'(0));
      step(1'b0, 1'b1, 1'b0, p, a);
      chk("fwd1_novalid", 128'(fwd1_hit), 128'(0));
      p.wb = 1'b0; step(1'b1, 1'b0, 1'b0, p, a);
      chk("fwd1_nowb", 128'(fwd1_hit), 128'(0));
      chk("fwd2_nowb", 128'(fwd2_hit), 128'(0));
      step(1'b0, 1'b1, 1'b0, p, a);
`endif

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         p = rand_pl();
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 19) == 0), p, a);
      end

      // Asynchronous reset mid-stream while FULL.
      p = rand_pl(); p.wb = 1'b1; step(1'b1, 1'b0, 1'b0, p, a);
      p = rand_pl(); p.wb = 1'b1; step(1'b1, 1'b0, 1'b0, p, a);
      p = rand_pl(); step(1'b1, 1'b0, 1'b0, p, a);
      valid_OF = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      exp_q.delete();
      chk("arst_valid", 128'(valid_ALU), 128'(0));
      chk("arst_iswb", 128'(isWb_ALU), 128'(0));
      chk("arst_payload", 128'({op1_ALU, op2_ALU, aluSignals_ALU, rd_ALU}), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("arst_ready", 128'(ready_OF), 128'(1));
      p = rand_pl();
      step(1'b0, 1'b1, 1'b0, p, a);
      step(1'b0, 1'b1, 1'b0, p, a);
      for (int i = 0; i < 20; i++) begin
         p = rand_pl();
         step(1'b1, 1'($urandom_range(0, 1)), 1'b0, p, a);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/of_alu_pipe_reg.md
# of_alu_pipe_reg

Parametrised, elastic pipeline register between the Operand Fetch (OF) and ALU stages. It carries operands, ALU control signals, destination register and write-back flag under a valid/ready handshake. A two-entry skid buffer gives full throughput with a registered `ready_OF`. It adds a synchronous flush for branch redirect and optional forwarding-hit detection.

## Interface
- `DATA_W`, default 32: operand width.
- `ALU_SIG_W`, default 13: ALU control bundle width.
- `REG_AW`, default 5: register address width.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `valid_OF` input 1: OF presents a valid instruction.
- `ready_OF` output 1: block can accept; driven directly from a register.
- `op1_OF`, `op2_OF` input DATA_W: operands.
- `aluSignals_OF` input ALU_SIG_W: ALU control.
- `rd_OF` input REG_AW: destination register.
- `isWb_OF` input 1: instruction writes back.
- `flush` input 1: discard all held and incoming entries.
- `valid_ALU` output 1: output entry valid.
- `ready_ALU` input 1: ALU consumes the output entry.
- `op1_ALU`, `op2_ALU` output DATA_W; `aluSignals_ALU` output ALU_SIG_W; `rd_ALU` output REG_AW: output payload.
- `isWb_ALU` output 1: registered isWb AND `valid_ALU`, so it is never asserted for a bubble.
- With `OFALU_PIPE_FWD_EN` only:
  - `rs1_OF`, `rs2_OF` input REG_AW: source registers.
  - `fwd1_hit`, `fwd2_hit` output 1: forwarding hits.

## Operation
- Storage: an output entry (OUT) and a skid entry (SKID), each holding a payload and a valid bit.
- Accept: `acc = valid_OF & ready_OF`. Consume: `con = valid_ALU & ready_ALU`.
- `ready_OF` is the registered value of `!SKID.valid`.
- Occupancy states:
  - EMPTY: OUT invalid, SKID invalid.
  - ONE: OUT valid, SKID invalid.
  - FULL: both valid.
- Transitions, when `flush` is 0:
  - EMPTY, acc → ONE; OUT ← input.
  - ONE, acc & con → ONE; OUT ← input.
  - ONE, acc & !con → FULL; SKID ← input.
  - ONE, !acc & con → EMPTY.
  - FULL, con → ONE; OUT ← SKID. `acc` is impossible in FULL because `ready_OF` is 0.
  - FULL, !con → FULL; both entries hold.
- Flush:
  - Both valid bits clear at the next edge, whatever the state, `acc` or `con`.
  - An entry accepted in the flush cycle is dropped.
  - `ready_OF` is 1 after the flush edge.
- Payload registers update only when loaded, with no other enable. Stale payload under `valid_ALU = 0` is don't-care, except that `isWb_ALU` is gated to 0.
- Ordering is strict FIFO. No entry is duplicated or lost except by flush.

## Timing
- Reset: all of the following are 0 asynchronously:
  - `valid_ALU`, `isWb_ALU`, `op1_ALU`, `op2_ALU`, `aluSignals_ALU`, `rd_ALU`.
  - Both internal valid bits, and the SKID payload.
- After reset `ready_OF` is 1. Reset asserted mid-operation discards all entries immediately.
- Latency: an entry accepted at edge N is visible on the ALU outputs after edge N, when the block was EMPTY or ONE with `con`.
- Throughput: 1 entry/cycle while `ready_ALU` stays high.
- Stall:
  - `ready_ALU` low for k cycles holds OUT stable.
  - At most one further entry is accepted into SKID, then `ready_OF` drops from the next cycle.
- No combinational path from `ready_ALU` to `ready_OF`. Outputs are registered, except `isWb_ALU` (one AND) and the `fwd*_hit` outputs.

## Configuration
- `OFALU_PIPE_FWD_EN` defined:
  - `fwd1_hit = valid_ALU & isWb(OUT) & (rd_ALU == rs1_OF) & (rs1_OF != 0)`; `fwd2_hit` likewise for `rs2_OF`.
  - Both are combinational; SKID is not compared.
- `OFALU_PIPE_FWD_EN` undefined:
  - The `rs*_OF` and `fwd*_hit` ports and the comparison logic are absent.
  - All other behaviour is identical.

## Test plan
- Reset: assert `rst_n = 0` mid-stream with FULL occupancy. Required: all outputs 0, `ready_OF = 1` after release, no stale entry emitted.
- Streaming: `ready_ALU = 1`, 8 back-to-back entries with `op1 = 0x10..0x17`. Required: emitted in order one cycle later, `ready_OF` constantly 1.
- Backpressure:
  - `ready_ALU = 0` for 3 cycles while entries A, B, C are offered. Required: A held, B in SKID, `ready_OF = 0`, C not accepted.
  - Release `ready_ALU`. Required: A, B, C emitted in consecutive cycles.
- Flush while FULL with simultaneous `valid_OF` (payload D). Required: `valid_ALU = 0` and `isWb_ALU = 0` next cycle, D never appears, `ready_OF = 1`.
- Flush in EMPTY. Required: no effect, next accepted entry appears after 1 cycle.
- FWD_EN: OUT holds `rd = 5` with `isWb = 1`, `rs1_OF = 5`, `rs2_OF = 0`. Required: `fwd1_hit = 1`, `fwd2_hit = 0`. With `isWb = 0` or `valid_ALU = 0`, both hits are 0.
